// File: rtl/swervolf_wb_pkg.sv
// swervolf_wb_pkg
// Shared encodings for the Wishbone initiator and its lane helper:
//   - command size encodings (SZ_*)
//   - response status codes (ST_*)
//   - initiator FSM state type
//   - latched command fields (cmd_t)
//   - cmd_illegal(): alignment / size legality check
package swervolf_wb_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ALIGN   = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BUSERR  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   // Only the fields needed after accept (read extraction, write/read
   // response data) are kept; address and data go straight to the bus flops.
   typedef struct packed {
      logic       we;
      logic [1:0] k;
      logic [1:0] size;
      logic       sgn;
   } cmd_t;

   function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] k);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return k[0];
         SZ_WORD: return (k != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/swervolf_wb_lane.sv
// swervolf_wb_lane
// Combinational byte-lane logic for a 32-bit Wishbone initiator.
// Ports:
//   i_size   access size (SZ_*)
//   i_k      byte offset adr[1:0]
//   i_signed sign-extend sub-word reads
//   i_wdat   right-justified write data
//   i_rdt    raw bus read data
//   o_sel    byte enables
//   o_wdat   lane-steered write data
//   o_rdat   right-justified, extended read data
module swervolf_wb_lane
   import swervolf_wb_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_k,
   input  logic        i_signed,
   input  logic [31:0] i_wdat,
   input  logic [31:0] i_rdt,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdat,
   output logic [31:0] o_rdat
);

   logic [4:0]  shamt;
   logic [31:0] r;

   assign shamt = {i_k, 3'b000};
   assign r     = i_rdt >> shamt;

   always_comb begin
      o_sel  = 4'b1111;
      o_wdat = i_wdat;
      o_rdat = i_rdt;
      case (i_size)
         SZ_BYTE: begin
            o_sel  = 4'b0001 << i_k;
            o_wdat = {24'b0, i_wdat[7:0]} << shamt;
            o_rdat = {{24{i_signed & r[7]}}, r[7:0]};
         end
         SZ_HALF: begin
            o_sel  = 4'b0011 << i_k;
            o_wdat = {16'b0, i_wdat[15:0]} << shamt;
            o_rdat = {{16{i_signed & r[15]}}, r[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/swervolf_wb_initiator.sv
// swervolf_wb_initiator
// Single-outstanding Wishbone classic initiator: one bus cycle per accepted
// command, one response per command. Misaligned / illegal-size commands are
// answered without touching the bus. A cycle with no ack/err is abandoned
// after TIMEOUT cycles.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready        command stream (valid/ready)
//   o_rsp_* / i_rsp_ready        response stream (valid/ready)
//   o_wb_* / i_wb_*              Wishbone classic initiator port
module swervolf_wb_initiator
   import swervolf_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_we,
   input  logic [31:0] i_cmd_adr,
   input  logic [31:0] i_cmd_dat,
   input  logic [1:0]  i_cmd_size,
   input  logic        i_cmd_signed,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_dat,
   output logic [1:0]  o_rsp_status,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   input  logic        i_wb_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT);

   state_t         state_q, state_d;
   cmd_t           cmd_q, cmd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           cmd_ready_q, cmd_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [31:0]    rsp_dat_q, rsp_dat_d;
   logic [1:0]     rsp_status_q, rsp_status_d;
   logic [31:0]    wb_adr_q, wb_adr_d;
   logic [31:0]    wb_dat_q, wb_dat_d;
   logic [3:0]     wb_sel_q, wb_sel_d;
   logic           wb_we_q, wb_we_d;
   logic           cyc_q, cyc_d;

   // One lane block serves both directions: while ready it steers the
   // incoming command's write data, afterwards it extracts read data for
   // the latched command.
   logic [1:0]     ln_size, ln_k;
   logic           ln_sgn;
   logic [3:0]     ln_sel;
   logic [31:0]    ln_wdat, ln_rdat;
   logic           accept;

   assign accept  = cmd_ready_q & i_cmd_valid;
   assign ln_size = cmd_ready_q ? i_cmd_size      : cmd_q.size;
   assign ln_k    = cmd_ready_q ? i_cmd_adr[1:0]  : cmd_q.k;
   assign ln_sgn  = cmd_ready_q ? i_cmd_signed    : cmd_q.sgn;

   swervolf_wb_lane u_lane (
      .i_size   (ln_size),
      .i_k      (ln_k),
      .i_signed (ln_sgn),
      .i_wdat   (i_cmd_dat),
      .i_rdt    (i_wb_rdt),
      .o_sel    (ln_sel),
      .o_wdat   (ln_wdat),
      .o_rdat   (ln_rdat)
   );

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      wb_adr_d     = wb_adr_q;
      wb_dat_d     = wb_dat_q;
      wb_sel_d     = wb_sel_q;
      wb_we_d      = wb_we_q;
      cyc_d        = cyc_q;
      case (state_q)
         S_IDLE: begin
            // Ready comes back one cycle after reset releases.
            cmd_ready_d = 1'b1;
            if (accept) begin
               cmd_ready_d = 1'b0;
               cmd_d = '{we: i_cmd_we, k: i_cmd_adr[1:0], size: i_cmd_size, sgn: i_cmd_signed};
               if (cmd_illegal(i_cmd_size, i_cmd_adr[1:0])) begin
                  state_d      = S_RSP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = ST_ALIGN;
                  rsp_dat_d    = '0;
               end else begin
                  state_d  = S_BUS;
                  cyc_d    = 1'b1;
                  cnt_d    = TO_LOAD;
                  wb_adr_d = {i_cmd_adr[31:2], 2'b00};
                  wb_dat_d = ln_wdat;
                  wb_sel_d = ln_sel;
                  wb_we_d  = i_cmd_we;
               end
            end
         end
         S_BUS: begin
            // err beats ack beats timeout; an ack in the final counted
            // cycle still completes normally.
            if (i_wb_err || i_wb_ack || cnt_q == CW'(1)) begin
               state_d     = S_RSP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               if (i_wb_err) begin
                  rsp_status_d = ST_BUSERR;
               end else if (i_wb_ack) begin
                  rsp_status_d = ST_OK;
                  rsp_dat_d    = cmd_q.we ? 32'd0 : ln_rdat;
               end else begin
                  rsp_status_d = ST_TIMEOUT;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RSP: begin
            if (i_rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         cmd_q        <= '0;
         cnt_q        <= '0;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= '0;
         wb_adr_q     <= '0;
         wb_dat_q     <= '0;
         wb_sel_q     <= '0;
         wb_we_q      <= 1'b0;
         cyc_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         wb_adr_q     <= wb_adr_d;
         wb_dat_q     <= wb_dat_d;
         wb_sel_q     <= wb_sel_d;
         wb_we_q      <= wb_we_d;
         cyc_q        <= cyc_d;
      end
   end

   assign o_cmd_ready  = cmd_ready_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_dat    = rsp_dat_q;
   assign o_rsp_status = rsp_status_q;
   assign o_wb_adr     = wb_adr_q;
   assign o_wb_dat     = wb_dat_q;
   assign o_wb_sel     = wb_sel_q;
   assign o_wb_we      = wb_we_q;
   assign o_wb_cyc     = cyc_q;
   assign o_wb_stb     = cyc_q;

endmodule

// File: tb/tb_swervolf_wb_initiator.sv
// Directed bench for swervolf_wb_initiator with TIMEOUT=4. Inputs change
// 1ns after each rising edge and outputs are sampled at the same point.
module tb_swervolf_wb_initiator;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic        i_cmd_we = 1'b0;
   logic [31:0] i_cmd_adr = '0;
   logic [31:0] i_cmd_dat = '0;
   logic [1:0]  i_cmd_size = '0;
   logic        i_cmd_signed = 1'b0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_dat;
   logic [1:0]  o_rsp_status;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic [31:0] i_wb_rdt = '0;
   logic        i_wb_ack = 1'b0;
   logic        i_wb_err = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   swervolf_wb_initiator #(.TIMEOUT(4)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_we     (i_cmd_we),
      .i_cmd_adr    (i_cmd_adr),
      .i_cmd_dat    (i_cmd_dat),
      .i_cmd_size   (i_cmd_size),
      .i_cmd_signed (i_cmd_signed),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_dat    (o_rsp_dat),
      .o_rsp_status (o_rsp_status),
      .o_wb_adr     (o_wb_adr),
      .o_wb_dat     (o_wb_dat),
      .o_wb_sel     (o_wb_sel),
      .o_wb_we      (o_wb_we),
      .o_wb_cyc     (o_wb_cyc),
      .o_wb_stb     (o_wb_stb),
      .i_wb_rdt     (i_wb_rdt),
      .i_wb_ack     (i_wb_ack),
      .i_wb_err     (i_wb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Present one command for exactly one edge; it must be accepted.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [1:0] size, input logic sgn);
      chk("ready_before_issue", {31'b0, o_cmd_ready}, 32'd1);
      i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_adr = adr;
      i_cmd_dat = dat; i_cmd_size = size; i_cmd_signed = sgn;
      step();
      i_cmd_valid = 1'b0;
   endtask

   // One-cycle ack with given read data.
   task automatic ack_with(input logic [31:0] rdt);
      i_wb_ack = 1'b1; i_wb_rdt = rdt;
      step();
      i_wb_ack = 1'b0; i_wb_rdt = '0;
   endtask

   // Consume the response, after which ready must be back.
   task automatic take();
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      chk("rsp_valid_after_take", {31'b0, o_rsp_valid}, 32'd0);
      chk("ready_after_take", {31'b0, o_cmd_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] held;

      // Reset state
      step(); step(); step();
      chk("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      chk("rst_cyc_stb_we", {29'b0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
      chk("rst_sel", {28'b0, o_wb_sel}, 32'd0);
      chk("rst_rsp_dat", o_rsp_dat, 32'd0);
      chk("rst_rsp_status", {30'b0, o_rsp_status}, 32'd0);
      chk("rst_adr", o_wb_adr, 32'd0);
      chk("rst_dat", o_wb_dat, 32'd0);
      i_rst = 1'b0;
      step();
      chk("ready_after_rst", {31'b0, o_cmd_ready}, 32'd1);

      // Word read at 0, syscon-like ack after one cycle of cyc
      issue(1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
      chk("wr0_cyc1", {30'b0, o_wb_cyc, o_wb_stb}, 32'd3);
      chk("wr0_ready_low", {31'b0, o_cmd_ready}, 32'd0);
      chk("wr0_sel", {28'b0, o_wb_sel}, 32'hF);
      chk("wr0_adr", o_wb_adr, 32'h0);
      step();
      chk("wr0_cyc2", {31'b0, o_wb_cyc}, 32'd1);
      chk("wr0_no_rsp_yet", {31'b0, o_rsp_valid}, 32'd0);
      ack_with(32'h8001_2345);
      chk("wr0_cyc_drop", {31'b0, o_wb_cyc}, 32'd0);
      chk("wr0_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
      chk("wr0_rsp_dat", o_rsp_dat, 32'h8001_2345);
      chk("wr0_rsp_status", {30'b0, o_rsp_status}, 32'd0);
      take();

      // Signed byte read at 3
      step();
      issue(1'b0, 32'h3, 32'h0, 2'd0, 1'b1);
      chk("sb_sel", {28'b0, o_wb_sel}, 32'h8);
      chk("sb_adr", o_wb_adr, 32'h0);
      chk("sb_we", {31'b0, o_wb_we}, 32'd0);
      ack_with(32'h80FF_0000);
      chk("sb_rsp_dat", o_rsp_dat, 32'hFFFF_FF80);
      chk("sb_status", {30'b0, o_rsp_status}, 32'd0);
      take();

      // Same read, unsigned
      step();
      issue(1'b0, 32'h3, 32'h0, 2'd0, 1'b0);
      ack_with(32'h80FF_0000);
      chk("ub_rsp_dat", o_rsp_dat, 32'h0000_0080);
      take();

      // Signed half read at 2
      step();
      issue(1'b0, 32'h2, 32'h0, 2'd1, 1'b1);
      chk("sh_sel", {28'b0, o_wb_sel}, 32'hC);
      ack_with(32'h8234_5678);
      chk("sh_rsp_dat", o_rsp_dat, 32'hFFFF_8234);
      take();

      // Half write at 0x12
      step();
      issue(1'b1, 32'h12, 32'h0000_BEEF, 2'd1, 1'b0);
      chk("hw_adr", o_wb_adr, 32'h10);
      chk("hw_sel", {28'b0, o_wb_sel}, 32'hC);
      chk("hw_dat", o_wb_dat, 32'hBEEF_0000);
      chk("hw_we", {31'b0, o_wb_we}, 32'd1);
      ack_with(32'hDEAD_BEEF);
      chk("hw_status", {30'b0, o_rsp_status}, 32'd0);
      chk("hw_rsp_dat", o_rsp_dat, 32'd0);
      take();

      // Byte write at 1
      step();
      issue(1'b1, 32'h21, 32'h1234_56A5, 2'd0, 1'b0);
      chk("bw_sel", {28'b0, o_wb_sel}, 32'h2);
      chk("bw_dat", o_wb_dat, 32'h0000_A500);
      ack_with(32'h0);
      take();

      // Misaligned word read: no bus cycle, status 1 next cycle
      step();
      issue(1'b0, 32'h2, 32'h0, 2'd2, 1'b0);
      chk("mis_cyc", {31'b0, o_wb_cyc}, 32'd0);
      chk("mis_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
      chk("mis_status", {30'b0, o_rsp_status}, 32'd1);
      take();

      // Misaligned half
      step();
      issue(1'b0, 32'h1, 32'h0, 2'd1, 1'b0);
      chk("mish_cyc", {31'b0, o_wb_cyc}, 32'd0);
      chk("mish_status", {30'b0, o_rsp_status}, 32'd1);
      take();

      // Size 3
      step();
      issue(1'b1, 32'h0, 32'h0, 2'd3, 1'b0);
      chk("sz3_cyc", {31'b0, o_wb_cyc}, 32'd0);
      chk("sz3_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
      chk("sz3_status", {30'b0, o_rsp_status}, 32'd1);
      chk("sz3_rsp_dat", o_rsp_dat, 32'd0);
      take();

      // Timeout: cyc high exactly 4 cycles
      step();
      issue(1'b0, 32'h4, 32'h0, 2'd2, 1'b0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!o_wb_cyc) break;
         n++;
         step();
      end
      chk("to_cyc_cycles", n, 32'd4);
      chk("to_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
      chk("to_status", {30'b0, o_rsp_status}, 32'd2);
      chk("to_rsp_dat", o_rsp_dat, 32'd0);
      take();

      // Ack in the 4th (last) cycle wins over timeout
      step();
      issue(1'b0, 32'h8, 32'h0, 2'd2, 1'b0);
      step(); step(); step();
      chk("ack4_cyc", {31'b0, o_wb_cyc}, 32'd1);
      ack_with(32'h1234_5678);
      chk("ack4_status", {30'b0, o_rsp_status}, 32'd0);
      chk("ack4_rsp_dat", o_rsp_dat, 32'h1234_5678);
      take();

      // err and ack together: bus error
      step();
      issue(1'b0, 32'hC, 32'h0, 2'd2, 1'b0);
      i_wb_err = 1'b1;
      ack_with(32'hFFFF_FFFF);
      i_wb_err = 1'b0;
      chk("err_cyc", {31'b0, o_wb_cyc}, 32'd0);
      chk("err_status", {30'b0, o_rsp_status}, 32'd3);
      chk("err_rsp_dat", o_rsp_dat, 32'd0);
      take();

      // Ack while idle is ignored
      step();
      ack_with(32'h5555_5555);
      chk("idle_ack_rsp", {31'b0, o_rsp_valid}, 32'd0);
      chk("idle_ack_cyc", {31'b0, o_wb_cyc}, 32'd0);

      // Backpressure: response held for 10 cycles
      issue(1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
      ack_with(32'hCAFE_F00D);
      held = o_rsp_dat;
      chk("bp_dat", held, 32'hCAFE_F00D);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", {31'b0, o_rsp_valid}, 32'd1);
         chk("bp_hold", o_rsp_dat, 32'hCAFE_F00D);
         chk("bp_ready_low", {31'b0, o_cmd_ready}, 32'd0);
      end
      take();

      // Reset mid-BUS
      step();
      issue(1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
      chk("mr_cyc_before", {31'b0, o_wb_cyc}, 32'd1);
      i_rst = 1'b1;
      step();
      chk("mr_cyc", {30'b0, o_wb_cyc, o_wb_stb}, 32'd0);
      chk("mr_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      chk("mr_ready_in_rst", {31'b0, o_cmd_ready}, 32'd0);
      i_rst = 1'b0;
      step();
      chk("mr_ready_after", {31'b0, o_cmd_ready}, 32'd1);
      chk("mr_rsp_after", {31'b0, o_rsp_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
